// File: rtl/txuart.sv
`timescale 1ns/1ps
// txuart -- 8N1 UART transmitter with a small input FIFO.
//
// Bytes enter through a valid/ready handshake, wait in a FIFO_DEPTH-entry
// FIFO and are sent LSB first on tx: one start bit (0), eight data bits and
// one stop bit (1). Every bit lasts DIVIDER = CLK_FREQ/BAUDRATE clocks, so a
// frame lasts 10*DIVIDER clocks. Back-to-back frames follow each other with
// no idle gap.
//
// Handshake: a byte moves from data into the FIFO on every rising edge where
// valid && ready. ready is high whenever the FIFO is not full (and never
// during reset). A push into a full FIFO is refused even if a pop happens
// on the same edge. valid may be withdrawn at any time without a transfer.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   data   in   [7:0] byte to transmit
//   valid  in   producer has a byte on data
//   ready  out  FIFO can accept a byte
//   tx     out  serial line, idles high, driven from a flop
//   busy   out  frame on the line or FIFO non-empty
//   level  out  [$clog2(FIFO_DEPTH):0] FIFO occupancy
module txuart #(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUDRATE   = 230_400,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int DIVIDER = CLK_FREQ / BAUDRATE;
    localparam int CW      = (DIVIDER < 2) ? 1 : $clog2(DIVIDER);
    localparam int PW      = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int LW      = PW + 1;

    // Reject illegal parameterisations at elaboration.
    if (DIVIDER < 2) begin : g_div_check
        $error("txuart: CLK_FREQ/BAUDRATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("txuart: FIFO_DEPTH must be a power of two and at least 2");
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    // ready comes only from the registered count, so a pop on the same edge
    // never lets a push into a full FIFO.
    assign ready = rst_n && (count != LW'(FIFO_DEPTH));
    assign push  = valid && ready;
    assign head  = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shreg;
    logic [7:0]    shreg_d;
    logic          tx_d;
    logic          bit_done;
    logic          fifo_nonempty;

    // The counter restarts at 0 on every bit boundary, so each bit is exactly
    // DIVIDER clocks and no error accumulates across the frame.
    assign bit_done      = (cnt == CW'(DIVIDER - 1));
    assign fifo_nonempty = (count != '0);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        tx_d      = tx;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    tx_d      = shreg[0];
                    shreg_d   = {1'b0, shreg[7:1]};
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d      = shreg[0];
                        shreg_d   = {1'b0, shreg[7:1]};
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shreg_d = head;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
            tx      <= tx_d;
        end
    end

    assign busy  = (state != S_IDLE) || fifo_nonempty;
    assign level = count;

endmodule
